// File: rtl/wrr_pkt_scheduler_if.sv
// Request/grant bundle between packet sources and the WRR packet scheduler.
//   iReq        : per-port level request
//   iEop        : end of packet for the currently granted port
//   iWeightLoad : single-cycle strobe capturing iWeight
//   iWeight     : per-port weight, 0 disables the port
//   oGnt        : registered one-hot grant, zero when idle
//   oGntIdx     : index of the granted port, meaningful while oGnt != 0
//   oRefresh    : one-cycle pulse on credit reload
interface wrr_pkt_scheduler_if #(
  parameter int unsigned ARB_NUM  = 4,
  parameter int unsigned WEIGHT_W = 4
);
  localparam int unsigned IDX_W = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1;

  logic [ARB_NUM-1:0]  iReq;
  logic                iEop;
  logic                iWeightLoad;
  logic [WEIGHT_W-1:0] iWeight [ARB_NUM];
  logic [ARB_NUM-1:0]  oGnt;
  logic [IDX_W-1:0]    oGntIdx;
  logic                oRefresh;

  modport master (
    output iReq, iEop, iWeightLoad, iWeight,
    input  oGnt, oGntIdx, oRefresh
  );

  modport slave (
    input  iReq, iEop, iWeightLoad, iWeight,
    output oGnt, oGntIdx, oRefresh
  );
endinterface

// File: rtl/wrr_pkt_scheduler.sv
// Weighted round-robin packet scheduler. Each port may be granted up to
// weight[i] packets per credit round; a grant is held until end of packet.
//   iClk : clock, rising edge
//   iRst : asynchronous active-high reset
//   bus  : wrr_pkt_scheduler_if.slave (requests, eop, weights in; grant, refresh out)
module wrr_pkt_scheduler #(
  parameter int unsigned ARB_NUM  = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input logic               iClk,
  input logic               iRst,
  wrr_pkt_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] weight [ARB_NUM];
  logic [WEIGHT_W-1:0] credit [ARB_NUM];
  logic [IDX_W-1:0]    ptr;
  logic                loadPending;
  logic [ARB_NUM-1:0]  gnt;
  logic [IDX_W-1:0]    gntIdx;
  logic                refresh;

  logic [ARB_NUM-1:0]  reqW;
  logic [ARB_NUM-1:0]  eligible;
  logic                anyElig;
  logic [IDX_W-1:0]    selIdx;

  assign bus.oGnt     = gnt;
  assign bus.oGntIdx  = gntIdx;
  assign bus.oRefresh = refresh;

  // Requesting ports with a nonzero weight, and those that still hold credit.
  always_comb begin
    reqW     = '0;
    eligible = '0;
    for (int unsigned i = 0; i < ARB_NUM; i++) begin
      reqW[IDX_W'(i)]     = bus.iReq[IDX_W'(i)] & (weight[IDX_W'(i)] != '0);
      eligible[IDX_W'(i)] = reqW[IDX_W'(i)] & (credit[IDX_W'(i)] != '0);
    end
  end

  // First eligible port searching circularly upward from ptr.
  always_comb begin
    int unsigned j;
    j       = 0;
    anyElig = 1'b0;
    selIdx  = '0;
    for (int unsigned k = 0; k < ARB_NUM; k++) begin
      j = 32'(ptr) + k;
      if (j >= ARB_NUM) j = j - ARB_NUM;
      if (!anyElig && eligible[IDX_W'(j)]) begin
        anyElig = 1'b1;
        selIdx  = IDX_W'(j);
      end
    end
  end

  // Scheduler FSM with registered grant/refresh outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      gnt         <= '0;
      gntIdx      <= '0;
      refresh     <= 1'b0;
      ptr         <= '0;
      loadPending <= 1'b0;
      for (int unsigned i = 0; i < ARB_NUM; i++) begin
        weight[IDX_W'(i)] <= WEIGHT_W'(1);
        credit[IDX_W'(i)] <= WEIGHT_W'(1);
      end
    end else begin
      refresh <= 1'b0;
      case (state)
        IDLE: begin
          if (loadPending) begin
            // New weights take effect as a fresh credit round; no grant this cycle.
            credit      <= weight;
            loadPending <= 1'b0;
            refresh     <= 1'b1;
          end else if (anyElig) begin
            gnt    <= ARB_NUM'(1) << selIdx;
            gntIdx <= selIdx;
            state  <= BUSY;
          end else if (|reqW) begin
            // Round exhausted while someone still wants service.
            credit  <= weight;
            refresh <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.iEop) begin
            gnt <= '0;
            if (credit[gntIdx] != '0) credit[gntIdx] <= credit[gntIdx] - WEIGHT_W'(1);
            ptr   <= (gntIdx == IDX_W'(ARB_NUM - 1)) ? '0 : gntIdx + IDX_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a strobe coinciding with a reload keeps the new load pending.
      if (bus.iWeightLoad) begin
        weight      <= bus.iWeight;
        loadPending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
module tb_wrr_pkt_scheduler;
  logic iClk;
  logic iRst;

  wrr_pkt_scheduler_if #(.ARB_NUM(4), .WEIGHT_W(4)) bus ();

  wrr_pkt_scheduler #(.ARB_NUM(4), .WEIGHT_W(4)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    bit isRef;
    int idx;
  } ev_t;

  ev_t  expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] prevGnt = 4'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 denotes a refresh pulse, otherwise a grant index.
  task automatic pushSeq(input int seq[$]);
    ev_t e;
    foreach (seq[k]) begin
      e.isRef = (seq[k] < 0);
      e.idx   = (seq[k] < 0) ? 0 : seq[k];
      expQ.push_back(e);
    end
  endtask

  task automatic scoreEvent(input bit isRef, input int idx, input logic [3:0] gnt);
    ev_t e;
    logic [3:0] expG;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got %s idx %0d with nothing expected at %0t",
               isRef ? "refresh" : "grant", idx, $time);
    end else begin
      e = expQ.pop_front();
      check("event_kind(1=refresh)", 32'(isRef), 32'(e.isRef));
      if (!e.isRef && !isRef) begin
        expG = 4'b0001 << e.idx;
        check("grant_idx", 32'(idx), 32'(e.idx));
        check("grant_onehot", 32'(gnt), 32'(expG));
      end
    end
  endtask

  // Monitor: a refresh pulse or the start of a grant is an output event.
  always @(negedge iClk) begin
    if (iRst) begin
      prevGnt = 4'b0;
    end else begin
      if (bus.oRefresh) scoreEvent(1'b1, 0, bus.oGnt);
      if (bus.oGnt != 4'b0 && prevGnt == 4'b0) scoreEvent(1'b0, int'(bus.oGntIdx), bus.oGnt);
      prevGnt = bus.oGnt;
    end
  end

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge iClk);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d events still pending after %0d cycles", name, expQ.size(), budget);
      expQ.delete();
    end
  endtask

  task automatic loadWeights(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3);
    bus.iWeight[0] = w0;
    bus.iWeight[1] = w1;
    bus.iWeight[2] = w2;
    bus.iWeight[3] = w3;
    bus.iWeightLoad = 1'b1;
    @(negedge iClk);
    bus.iWeightLoad = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    iRst = 1'b1;
    bus.iReq = 4'b0;
    bus.iEop = 1'b0;
    bus.iWeightLoad = 1'b0;
    bus.iWeight[0] = 4'd0;
    bus.iWeight[1] = 4'd0;
    bus.iWeight[2] = 4'd0;
    bus.iWeight[3] = 4'd0;
    #1;
    check("reset_gnt", 32'(bus.oGnt), 32'd0);
    check("reset_gntidx", 32'(bus.oGntIdx), 32'd0);
    check("reset_refresh", 32'(bus.oRefresh), 32'd0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;

    // Reset weights: plain round robin, refresh after every 4 grants.
    bus.iReq = 4'hF;
    bus.iEop = 1'b1;
    seq = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1};
    pushSeq(seq);
    waitDrain("rr_reset_weights", 100);
    bus.iReq = 4'h0;

    // Weights 4,3,2,1: load refresh, then weighted order and a round refresh.
    seq = '{-1};
    pushSeq(seq);
    loadWeights(4'd4, 4'd3, 4'd2, 4'd1);
    waitDrain("wrr_load_refresh", 20);
    bus.iReq = 4'hF;
    seq = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0, -1};
    pushSeq(seq);
    waitDrain("wrr_4321", 200);
    bus.iReq = 4'h0;

    // Reset, then weight[1]=0: port 1 never granted.
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    seq = '{-1};
    pushSeq(seq);
    loadWeights(4'd2, 4'd0, 4'd2, 4'd2);
    waitDrain("zero_weight_load", 20);
    bus.iReq = 4'hF;
    seq = '{0, 2, 3, 0, 2, 3, -1};
    pushSeq(seq);
    waitDrain("zero_weight_order", 200);
    bus.iReq = 4'h0;

    // Grant port 2, drop its request, hold iEop low: grant persists.
    bus.iEop = 1'b0;
    bus.iReq = 4'b0100;
    seq = '{2};
    pushSeq(seq);
    waitDrain("hold_grant_start", 20);
    bus.iReq = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      check("hold_gnt", 32'(bus.oGnt), 32'h4);
      check("hold_gntidx", 32'(bus.oGntIdx), 32'd2);
    end
    bus.iEop = 1'b1;
    @(negedge iClk);
    #1;
    bus.iEop = 1'b0;
    check("eop_clears_gnt", 32'(bus.oGnt), 32'd0);
    check("credit2_decrement", 32'(dut.credit[2]), 32'd1);

    // Weight load coinciding with iEop: grant completes, then reload cycle.
    bus.iReq = 4'b0001;
    seq = '{0};
    pushSeq(seq);
    waitDrain("busy_load_grant", 20);
    seq = '{-1, 0};
    pushSeq(seq);
    bus.iEop = 1'b1;
    bus.iWeight[0] = 4'd3;
    bus.iWeight[1] = 4'd5;
    bus.iWeight[2] = 4'd6;
    bus.iWeight[3] = 4'd7;
    bus.iWeightLoad = 1'b1;
    @(negedge iClk);
    bus.iEop = 1'b0;
    bus.iWeightLoad = 1'b0;
    check("eop_with_load_gnt", 32'(bus.oGnt), 32'd0);
    @(negedge iClk);
    #1;
    check("reload_no_grant", 32'(bus.oGnt), 32'd0);
    check("reload_credit0", 32'(dut.credit[0]), 32'd3);
    check("reload_credit1", 32'(dut.credit[1]), 32'd5);
    check("reload_credit2", 32'(dut.credit[2]), 32'd6);
    check("reload_credit3", 32'(dut.credit[3]), 32'd7);
    waitDrain("busy_load_regrant", 20);

    // Asynchronous reset mid-packet, then arbitration restarts at port 0.
    #2;
    iRst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(bus.oGnt), 32'd0);
    check("async_rst_gntidx", 32'(bus.oGntIdx), 32'd0);
    check("async_rst_refresh", 32'(bus.oRefresh), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    bus.iReq = 4'hF;
    bus.iEop = 1'b1;
    seq = '{0, 1, 2, 3, -1};
    pushSeq(seq);
    waitDrain("post_reset_rr", 100);
    bus.iReq = 4'h0;
    bus.iEop = 1'b0;

    repeat (3) @(negedge iClk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wrr_pkt_scheduler.md
WRR_PKT_SCHEDULER -- requirements
Module: wrr_pkt_scheduler

Interface
REQ-001 SHALL have parameter ARB_NUM, default 4: number of requesting ports.
REQ-002 SHALL have parameter WEIGHT_W, default 4: width of each weight and credit counter.
REQ-003 SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port iReq, input, ARB_NUM bits: per-port packet request, level-sensitive.
REQ-006 SHALL have port iEop, input, 1 bit: end-of-packet for the currently granted port.
REQ-007 SHALL have port iWeightLoad, input, 1 bit: single-cycle strobe that captures iWeight.
REQ-008 SHALL have port iWeight, input, ARB_NUM x WEIGHT_W unpacked array: per-port weight; 0 disables the port.
REQ-009 SHALL have port oGnt, output, ARB_NUM bits: registered one-hot grant, all-zero when idle.
REQ-010 SHALL have port oGntIdx, output, clog2(ARB_NUM) bits: index of the granted port, valid while oGnt != 0.
REQ-011 SHALL have port oRefresh, output, 1 bit: one-cycle pulse when credits are reloaded.

Function
REQ-012 SHALL have a two-state FSM, IDLE and BUSY.
REQ-013 SHALL hold per-port registers: weight[i], credit[i], an RR pointer ptr, and a load-pending flag.
REQ-014 SHALL define eligible[i] = iReq[i] & (credit[i] != 0) & (weight[i] != 0).
REQ-015 SHALL, in IDLE with load-pending set, reload credit[i] = weight[i] for all i, clear load-pending, pulse oRefresh and issue no grant that cycle.
REQ-016 SHALL, in IDLE with load-pending clear, no eligible port, and any port with iReq & (weight != 0), reload all credits from weights, pulse oRefresh and issue no grant that cycle.
REQ-017 SHALL, in IDLE with any eligible port, select the first eligible index found searching circularly from ptr upward (wrapping ARB_NUM-1 to 0), set oGnt/oGntIdx at that edge and enter BUSY.
REQ-018 SHALL hold oGnt constant in BUSY regardless of iReq changes until iEop is sampled high.
REQ-019 SHALL, on the edge where iEop=1 in BUSY: clear oGnt, decrement credit of the granted port by 1, set ptr = (granted idx + 1) mod ARB_NUM, and enter IDLE.
REQ-020 SHALL ignore iEop while in IDLE.
REQ-021 SHALL give a grant latency of one edge from an eligible request seen in IDLE, and a minimum gap of one IDLE cycle between consecutive grants.
REQ-022 SHALL, on iWeightLoad=1 in any state, capture iWeight into weight[] at that edge and set load-pending; credits are not changed until REQ-015 applies.
REQ-023 SHALL keep the in-flight grant unaffected when iWeightLoad coincides with BUSY or with iEop; the reload occurs in the following IDLE cycle.
REQ-024 SHALL never decrement credit below 0 or reload a credit to a value other than weight[i].
REQ-025 SHALL keep oRefresh at 0 in every cycle other than the reload cycles of REQ-015/REQ-016.

Reset
REQ-026 SHALL, while iRst=1, force asynchronously: FSM=IDLE, oGnt=0, oGntIdx=0, oRefresh=0, ptr=0, weight[i]=1, credit[i]=1, load-pending=0.
REQ-027 SHALL abandon any in-flight packet grant on reset mid-BUSY, without decrementing credit.
REQ-028 SHALL resume arbitration from the first IDLE cycle after iRst deasserts.

Verification
REQ-029 SHALL cover: weights {4,3,2,1} loaded, all iReq=1, iEop tied 1 -> refresh pulse, then grant order 0,1,2,3,0,1,2,0,1,0, each grant 1 cycle with a 1-cycle gap, then a refresh pulse and the pattern repeats.
REQ-030 SHALL cover: reset weights, all iReq=1 -> plain round robin 0,1,2,3 with a refresh pulse after every 4 grants.
REQ-031 SHALL cover: grant port 2, drop iReq[2] and hold iEop=0 for 5 cycles -> oGnt stays 4'b0100 until iEop, then credit[2] decrements by 1.
REQ-032 SHALL cover: weight[1]=0, all others 2, all iReq=1 -> port 1 is never granted; order is 0,2,3,0,2,3.
REQ-033 SHALL cover: iWeightLoad pulsed during BUSY together with iEop -> current grant completes, the next IDLE cycle shows oRefresh=1 with no grant, and credits equal the new weights.
REQ-034 SHALL cover: iRst asserted mid-packet -> oGnt=0 immediately (asynchronously); after release the first grant goes to port 0.
